id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register; sits directly downstream of unit_control and the register file.
//  Latches decoded control (MemREG..ALUOP), operands, immediate and register addresses for EX.
//  Uses a valid/ready handshake in both directions.
//  Detects load-use hazards and inserts exactly one bubble.
// PARAMETERS
//  DATA_W  32  operand / immediate / PC width
//  REG_W   5   register-address width
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       synchronous, active-high
//  in_valid    in   1       ID holds a decoded instruction
//  in_ready    out  1       stage accepts the ID entry this cycle
//  flush       in   1       kill entry held in stage (branch taken)
//  id_MemREG, id_RegWRITE, id_MemWRITE, id_Branch, id_MemRead, id_ALUSrc, id_RegDst  in  1 each  from unit_control
//  id_ALUOP    in   3       from unit_control
//  id_pc4      in   DATA_W  PC+4 of instruction
//  id_rd1, id_rd2  in  DATA_W  register-file read data
//  id_imm      in   DATA_W  sign-extended immediate
//  id_rs, id_rt, id_rd  in  REG_W  register addresses
//  out_valid   out  1       EX entry valid
//  out_ready   in   1       EX consumes entry
//  ex_*        out  same    registered copies of every id_* field (ex_MemREG..ex_rd)
//  hazard_stall  out 1      load-use stall active (comb.)
// BEHAVIOUR
//  - Reset: out_valid=0, all ex_* = 0, counters = 0. Reset overrides flush and all handshakes.
//  - hazard_stall = in_valid & out_valid & ex_MemRead & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt).
//  - in_ready = (~out_valid | out_ready) & ~hazard_stall & ~flush.
//  - accept = in_valid & in_ready. On accept: ex_* <= id_*, out_valid <= 1 (1-cycle latency).
//  - No accept and out_ready: out_valid <= 0, making a bubble.
//    The bubble's ex_RegWRITE/MemWRITE/MemRead/Branch are registered as 0.
//  - No accept and ~out_ready: hold all ex_* and out_valid unchanged.
//  - flush=1: out_valid <= 0 and the four enables listed above <= 0. ID entry is not accepted.
//  - Load-use: load in stage plus dependent in ID.
//    The load leaves on out_ready while hazard holds in_ready=0, so the next cycle is a bubble.
//    The dependent is accepted the cycle after that. Exactly 1 bubble when out_ready=1 throughout.
//  - Register 0 never causes a hazard. A hazard requires out_valid=1; a stale ex_MemRead is ignored.
//  - Enable outputs ex_RegWRITE/MemWRITE/MemRead/Branch are ANDed with out_valid at the port.
//    They are never X or 1 while invalid, even if unit_control drove X on a default opcode.
//  - Data fields (rd1/rd2/imm/pc4) are don't-care while out_valid=0 but hold their last value.
// CONFIGURATION
//  ID_EX_STATS_EN defined:
//   - adds outputs stall_cnt[31:0] (cycles with hazard_stall=1) and flush_cnt[31:0] (cycles with flush=1).
//   - Both counters wrap at 2^32 and reset to 0.
//  ID_EX_STATS_EN undefined: no counters, no extra ports; behaviour otherwise identical.
// TESTING
//  1. Reset held 2 cycles with in_valid=1 -> out_valid=0, all ex_* 0, in_ready=0 during reset.
//  2. R-type (RegWRITE=1, RegDst=1, ALUOP=010), rd1=5, rd2=7, out_ready=1
//     -> next cycle out_valid=1, ex_rd1=5, ex_rd2=7, ex_RegWRITE=1.
//  3. lw rt=8 in stage; then add rs=8, out_ready=1
//     -> hazard_stall=1 for 1 cycle, then one bubble (out_valid=0), then add in stage.
//  4. lw rt=0 in stage, ID rs=0 -> hazard_stall=0, accepted back-to-back.
//  5. out_ready=0 for 3 cycles with in_valid=1 -> ex_* stable, in_ready=0; accepted on the cycle out_ready rises.
//  6. sw in stage, flush=1 same cycle as in_valid=1 -> next cycle out_valid=0, ex_MemWRITE=0.
//     With ID_EX_STATS_EN defined, flush_cnt=1.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with valid/ready handshake and load-use bubble insertion
// Optional statistics counters (stall_cnt, flush_cnt) are enabled by defining ID_EX_STATS_EN.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              id_MemREG,
  input  logic              id_RegWRITE,
  input  logic              id_MemWRITE,
  input  logic              id_Branch,
  input  logic              id_MemRead,
  input  logic              id_ALUSrc,
  input  logic              id_RegDst,
  input  logic [2:0]        id_ALUOP,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ex_MemREG,
  output logic              ex_RegWRITE,
  output logic              ex_MemWRITE,
  output logic              ex_Branch,
  output logic              ex_MemRead,
  output logic              ex_ALUSrc,
  output logic              ex_RegDst,
  output logic [2:0]        ex_ALUOP,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic              hazard_stall
`ifdef ID_EX_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  logic              valid_q;
  logic              memreg_q;
  logic              regwrite_q;
  logic              memwrite_q;
  logic              branch_q;
  logic              memread_q;
  logic              alusrc_q;
  logic              regdst_q;
  logic [2:0]        aluop_q;
  logic [DATA_W-1:0] pc4_q;
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd2_q;
  logic [DATA_W-1:0] imm_q;
  logic [REG_W-1:0]  rs_q;
  logic [REG_W-1:0]  rt_q;
  logic [REG_W-1:0]  rd_q;
  logic              accept;

  // Load in stage whose destination feeds the instruction waiting in ID; r0 is never a dependency
  assign hazard_stall = in_valid & valid_q & memread_q & (rt_q != '0) &
                        ((rt_q == id_rs) | (rt_q == id_rt));

  // Nothing is accepted while reset is asserted, during a flush or while the load-use hazard holds
  assign in_ready = ~reset & (~valid_q | out_ready) & ~hazard_stall & ~flush;
  assign accept   = in_valid & in_ready;

  // Pipeline register: flush kills the entry, accept loads ID, a consumed entry with no refill becomes a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      memreg_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      branch_q   <= 1'b0;
      memread_q  <= 1'b0;
      alusrc_q   <= 1'b0;
      regdst_q   <= 1'b0;
      aluop_q    <= '0;
      pc4_q      <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      branch_q   <= 1'b0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      memreg_q   <= id_MemREG;
      regwrite_q <= id_RegWRITE;
      memwrite_q <= id_MemWRITE;
      branch_q   <= id_Branch;
      memread_q  <= id_MemRead;
      alusrc_q   <= id_ALUSrc;
      regdst_q   <= id_RegDst;
      aluop_q    <= id_ALUOP;
      pc4_q      <= id_pc4;
      rd1_q      <= id_rd1;
      rd2_q      <= id_rd2;
      imm_q      <= id_imm;
      rs_q       <= id_rs;
      rt_q       <= id_rt;
      rd_q       <= id_rd;
    end else if (out_ready) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      branch_q   <= 1'b0;
    end
  end

  // State-changing enables are gated by valid so a bubble or an X from unit_control never leaks into EX
  assign out_valid   = valid_q;
  assign ex_MemREG   = memreg_q;
  assign ex_RegWRITE = regwrite_q & valid_q;
  assign ex_MemWRITE = memwrite_q & valid_q;
  assign ex_Branch   = branch_q & valid_q;
  assign ex_MemRead  = memread_q & valid_q;
  assign ex_ALUSrc   = alusrc_q;
  assign ex_RegDst   = regdst_q;
  assign ex_ALUOP    = aluop_q;
  assign ex_pc4      = pc4_q;
  assign ex_rd1      = rd1_q;
  assign ex_rd2      = rd2_q;
  assign ex_imm      = imm_q;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_rd       = rd_q;

`ifdef ID_EX_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Free-running wrap-around counters of hazard-stall and flush cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hazard_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush)        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready, hazard_stall;
  logic        id_MemREG, id_RegWRITE, id_MemWRITE, id_Branch, id_MemRead, id_ALUSrc, id_RegDst;
  logic [2:0]  id_ALUOP, ex_ALUOP;
  logic [31:0] id_pc4, id_rd1, id_rd2, id_imm, ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  id_rs, id_rt, id_rd, ex_rs, ex_rt, ex_rd;
  logic        ex_MemREG, ex_RegWRITE, ex_MemWRITE, ex_Branch, ex_MemRead, ex_ALUSrc, ex_RegDst;
`ifdef ID_EX_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] m_stall, m_flush;
`endif

  id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .id_MemREG(id_MemREG), .id_RegWRITE(id_RegWRITE), .id_MemWRITE(id_MemWRITE),
    .id_Branch(id_Branch), .id_MemRead(id_MemRead), .id_ALUSrc(id_ALUSrc), .id_RegDst(id_RegDst),
    .id_ALUOP(id_ALUOP), .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .ex_MemREG(ex_MemREG), .ex_RegWRITE(ex_RegWRITE), .ex_MemWRITE(ex_MemWRITE),
    .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead), .ex_ALUSrc(ex_ALUSrc), .ex_RegDst(ex_RegDst),
    .ex_ALUOP(ex_ALUOP), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .hazard_stall(hazard_stall)
`ifdef ID_EX_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [152:0] sb_q[$];
  logic         m_valid = 1'b0;
  logic         m_memread = 1'b0;
  logic [4:0]   m_rt = '0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [152:0] pack_id();
    return {id_MemREG, id_RegWRITE, id_MemWRITE, id_Branch, id_MemRead, id_ALUSrc, id_RegDst,
            id_ALUOP, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd};
  endfunction

  function automatic logic [152:0] pack_ex();
    return {ex_MemREG, ex_RegWRITE, ex_MemWRITE, ex_Branch, ex_MemRead, ex_ALUSrc, ex_RegDst,
            ex_ALUOP, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd};
  endfunction

  // kind: 0 = R-type, 1 = lw, 2 = sw
  task automatic set_instr(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    id_MemREG   = (kind == 1);
    id_RegWRITE = (kind != 2);
    id_MemWRITE = (kind == 2);
    id_Branch   = 1'b0;
    id_MemRead  = (kind == 1);
    id_ALUSrc   = (kind != 0);
    id_RegDst   = (kind == 0);
    id_ALUOP    = (kind == 0) ? 3'b010 : 3'b000;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_rd1 = a; id_rd2 = b;
    id_imm = a ^ 32'h0000_0055;
    id_pc4 = b + 32'd4;
  endtask

  // One clock: check outputs at the falling edge against the model, then advance model at the rising edge
  task automatic tick();
    logic hz, rdy, acc;
    @(negedge clk);
    hz  = in_valid & m_valid & m_memread & (m_rt != 5'd0) & ((m_rt == id_rs) | (m_rt == id_rt));
    rdy = ~reset & (~m_valid | out_ready) & ~hz & ~flush;
    acc = in_valid & rdy;
    check("hazard_stall", hazard_stall, hz);
    check("in_ready", in_ready, rdy);
    check("out_valid", out_valid, m_valid);
    if (!m_valid)
      check("bubble_en", {ex_RegWRITE, ex_MemWRITE, ex_MemRead, ex_Branch}, 4'b0);
    if (m_valid && out_ready && !flush && !reset) begin
      if (sb_q.size() == 0) check("sb_underflow", 1, 0);
      else check("sb_entry", pack_ex(), sb_q.pop_front());
    end
`ifdef ID_EX_STATS_EN
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
`endif
    @(posedge clk);
`ifdef ID_EX_STATS_EN
    if (reset) begin m_stall = 0; m_flush = 0; end
    else begin m_stall += {31'd0, hz}; m_flush += {31'd0, flush}; end
`endif
    if (reset) begin
      m_valid = 1'b0; m_memread = 1'b0; m_rt = '0; sb_q.delete();
    end else if (flush) begin
      if (m_valid && sb_q.size() != 0) void'(sb_q.pop_front());
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1; m_memread = id_MemRead; m_rt = id_rt;
      sb_q.push_back(pack_id());
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  initial begin
`ifdef ID_EX_STATS_EN
    m_stall = 0; m_flush = 0;
`endif
    // 1. reset for two cycles with an instruction offered
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    set_instr(0, 5'd1, 5'd2, 5'd3, 32'd11, 32'd22);
    tick(); tick();
    check("rst_ex_zero", pack_ex(), 0);
    check("rst_out_valid", out_valid, 0);
    reset = 1'b0;

    // 2. R-type rd1=5 rd2=7
    set_instr(0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    tick();
    check("rtype_valid", out_valid, 1);
    check("rtype_rd1", ex_rd1, 32'd5);
    check("rtype_rd2", ex_rd2, 32'd7);
    check("rtype_regwrite", ex_RegWRITE, 1);
    check("rtype_aluop", ex_ALUOP, 3'b010);
    in_valid = 1'b0;
    tick();

    // 3. lw rt=8 then dependent add rs=8: one stall cycle, one bubble
    in_valid = 1'b1;
    set_instr(1, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0);
    tick();
    set_instr(0, 5'd8, 5'd3, 5'd9, 32'h33, 32'h44);
    check("lu_hazard_on", hazard_stall, 1);
    check("lu_in_ready_off", in_ready, 0);
    tick();
    check("lu_bubble", out_valid, 0);
    check("lu_hazard_off", hazard_stall, 0);
    tick();
    check("lu_add_in", out_valid, 1);
    check("lu_add_rs", ex_rs, 5'd8);
    in_valid = 1'b0;
    tick();

    // 4. lw rt=0 followed by rs=0: no hazard, back-to-back
    in_valid = 1'b1;
    set_instr(1, 5'd2, 5'd0, 5'd0, 32'h200, 32'h0);
    tick();
    set_instr(0, 5'd0, 5'd0, 5'd4, 32'h55, 32'h66);
    check("r0_no_hazard", hazard_stall, 0);
    check("r0_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    tick();

    // 5. back-pressure for three cycles
    in_valid = 1'b1;
    set_instr(0, 5'd5, 5'd6, 5'd7, 32'hAAAA, 32'hBBBB);
    tick();
    out_ready = 1'b0;
    set_instr(0, 5'd9, 5'd10, 5'd11, 32'hCCCC, 32'hDDDD);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_rd1", ex_rd1, 32'hAAAA);
    end
    out_ready = 1'b1;
    tick();
    check("bp_new_rd1", ex_rd1, 32'hCCCC);
    in_valid = 1'b0;
    tick();

    // 6. sw in stage killed by flush while ID offers an instruction
    in_valid = 1'b1;
    set_instr(2, 5'd3, 5'd4, 5'd0, 32'h10, 32'h20);
    tick();
    out_ready = 1'b0; flush = 1'b1;
    set_instr(0, 5'd1, 5'd1, 5'd1, 32'h1, 32'h2);
    tick();
    check("flush_valid", out_valid, 0);
    check("flush_memwrite", ex_MemWRITE, 0);
`ifdef ID_EX_STATS_EN
    check("flush_cnt_one", flush_cnt, 32'd1);
`endif
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // random traffic with small register numbers to provoke hazards
    for (int i = 0; i < 200; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      set_instr(int'($urandom_range(0, 2)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 31)), $urandom, $urandom);
      tick();
    end

    // drain and final reset
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("drain_empty", sb_q.size(), 0);
    reset = 1'b1;
    tick();
    check("final_rst_ex", pack_ex(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
